sdram_arbiter: RTL



---
 rtl/sdram_arbiter_if.sv | 32 +++
 rtl/sdram_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - SDRAM controller CPU-port bus between the arbiter and SDRAMcontroller
// Purpose: carries one line transaction (address, write line, direction, start level,
//          done pulse, read line) between the arbiter and the controller.
// Ports (signals):
//   sdc_addr  [ADDR_W] line address          master -> slave
//   sdc_data  [DATA_W] write line            master -> slave
//   sdc_we             1=write, 0=read       master -> slave
//   sdc_start          transaction level     master -> slave
//   sdc_done           one-cycle completion  slave  -> master
//   sdc_q     [DATA_W] read line             slave  -> master
// Modports: master = arbiter side, slave = controller side.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0] sdc_addr;
    logic [DATA_W-1:0] sdc_data;
    logic              sdc_we;
    logic              sdc_start;
    logic              sdc_done;
    logic [DATA_W-1:0] sdc_q;

    modport master (
        output sdc_addr, sdc_data, sdc_we, sdc_start,
        input  sdc_done, sdc_q
    );

    modport slave (
        input  sdc_addr, sdc_data, sdc_we, sdc_start,
        output sdc_done, sdc_q
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - three-port round-robin arbiter in front of the SDRAM controller CPU port
// Purpose: shares one SDRAM line port between icache (p0), dcache (p1) and GPU/DMA (p2),
//          one outstanding transaction at a time.
// Ports:
//   clk, resetn                     memory clock, asynchronous active-low reset
//   pN_addr/pN_data/pN_we/pN_start  requester N line request (level, held until pN_done)
//   pN_done/pN_q                    requester N completion pulse and last read line
//   sdc (sdram_arbiter_if.master)   controller CPU port
//   busy                            transaction in progress
//   grant_id                        currently or last granted port
//   err_spurious                    sticky: controller done seen outside WAIT
// Optional feature: define SDRAM_ARB_GPU_PRIO_EN to give p2 absolute priority, with
//                   p0/p1 round-robin between themselves.
module sdram_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    input  logic              p0_we,
    input  logic              p0_start,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_q,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    input  logic              p1_we,
    input  logic              p1_start,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_q,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_data,
    input  logic              p2_we,
    input  logic              p2_start,
    output logic              p2_done,
    output logic [DATA_W-1:0] p2_q,
    sdram_arbiter_if.master   sdc,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic              err_spurious
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] rr_ptr;
    logic [3:0] req;        // bit 3 pads the vector so a 2-bit index never leaves it
    logic       any_req;
    logic [1:0] win;
    logic       sdc_start_c;
    logic [2:0] done_c;

    assign req     = {1'b0, p2_start, p1_start, p0_start};
    assign any_req = p0_start | p1_start | p2_start;

`ifdef SDRAM_ARB_GPU_PRIO_EN
    // p2 always wins; rr_ptr stays in 0/1 and only rotates between p0 and p1.
    always_comb begin
        win = 2'd0;
        if (p2_start)
            win = 2'd2;
        else if (req[rr_ptr])
            win = rr_ptr;
        else
            win = {1'b0, ~rr_ptr[0]};
    end
`else
    logic [1:0] cand1, cand2;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Scan rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first requester wins.
    always_comb begin
        cand1 = next_port(rr_ptr);
        cand2 = next_port(cand1);
        win   = cand2;
        if (req[rr_ptr])
            win = rr_ptr;
        else if (req[cand1])
            win = cand1;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sdc_start_c = 1'b0;
        done_c      = 3'b000;
        case (state)
            IDLE:  if (any_req) state_nxt = ISSUE;
            ISSUE: begin
                sdc_start_c = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                sdc_start_c = 1'b1;
                if (sdc.sdc_done) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 3'b001 << grant_id;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sdc.sdc_start = sdc_start_c;
    assign p0_done       = done_c[0];
    assign p1_done       = done_c[1];
    assign p2_done       = done_c[2];
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr       <= 2'd0;
            grant_id     <= 2'd0;
            sdc.sdc_addr <= '0;
            sdc.sdc_data <= '0;
            sdc.sdc_we   <= 1'b0;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            err_spurious <= 1'b0;
        end else begin
            // A done outside WAIT belongs to no transaction of ours (e.g. one aborted by reset).
            if (sdc.sdc_done && state != WAIT)
                err_spurious <= 1'b1;
            case (state)
                IDLE: if (any_req) begin
                    grant_id <= win;
                    case (win)
                        2'd0: begin
                            sdc.sdc_addr <= p0_addr;
                            sdc.sdc_data <= p0_data;
                            sdc.sdc_we   <= p0_we;
                        end
                        2'd1: begin
                            sdc.sdc_addr <= p1_addr;
                            sdc.sdc_data <= p1_data;
                            sdc.sdc_we   <= p1_we;
                        end
                        default: begin
                            sdc.sdc_addr <= p2_addr;
                            sdc.sdc_data <= p2_data;
                            sdc.sdc_we   <= p2_we;
                        end
                    endcase
                end
                WAIT: if (sdc.sdc_done && !sdc.sdc_we) begin
                    case (grant_id)
                        2'd0:    p0_q <= sdc.sdc_q;
                        2'd1:    p1_q <= sdc.sdc_q;
                        default: p2_q <= sdc.sdc_q;
                    endcase
                end
                DONE: begin
`ifdef SDRAM_ARB_GPU_PRIO_EN
                    if (grant_id != 2'd2)
                        rr_ptr <= {1'b0, ~grant_id[0]};
`else
                    rr_ptr <= (grant_id == 2'd2) ? 2'd0 : grant_id + 2'd1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
